// File: rtl/rotate_cipher_pkg.sv
// rotate_cipher_pkg
//   Shared definitions for the rotate-cipher pipeline: legal data-width
//   range, the log2 helper used to size the key and pipeline depth, and the
//   encrypt/decrypt mode encoding carried alongside every word.
package rotate_cipher_pkg;

  // Legal range for the data word width (must also be a power of two).
  localparam int unsigned WIDTH_MIN = 4;
  localparam int unsigned WIDTH_MAX = 64;

  // Per-word transform direction: encrypt rotates left, decrypt rotates right.
  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  // Ceiling log2; exact for the power-of-two widths this block accepts.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rotate_cipher_pipe_rot_stage.sv
// rot_stage
//   One register stage of the rotate pipeline. The incoming word is rotated
//   by 2^STAGE (left for encrypt, right for decrypt) when bit STAGE of its
//   key is set, then captured together with its key and mode so later
//   stages see the word's own configuration.
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   valid_i, ready_o  upstream handshake
//   data_i/key_i/mode_i  word and its per-word configuration
//   valid_o, ready_i  downstream handshake
//   data_o/key_o/mode_o  registered word and configuration
module rot_stage
  import rotate_cipher_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned KEY_W = 3,
  parameter int unsigned STAGE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic [KEY_W-1:0] key_i,
  input  mode_e            mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [KEY_W-1:0] key_o,
  output mode_e            mode_o
);

  localparam int unsigned SHIFT = 1 << STAGE;

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [KEY_W-1:0] key_q;
  mode_e            mode_q;

  logic [WIDTH-1:0] rot_l;
  logic [WIDTH-1:0] rot_r;
  logic [WIDTH-1:0] data_d;

  assign rot_l = {data_i[WIDTH-1-SHIFT:0], data_i[WIDTH-1:WIDTH-SHIFT]};
  assign rot_r = {data_i[SHIFT-1:0], data_i[WIDTH-1:SHIFT]};

  always_comb begin
    data_d = data_i;
    if (key_i[STAGE]) data_d = (mode_i == MODE_DEC) ? rot_r : rot_l;
  end

  // The stage may take a new word when it is empty or its word leaves now.
  assign ready_o = !valid_q || ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      key_q   <= '0;
      mode_q  <= MODE_ENC;
    end else if (ready_o) begin
      valid_q <= valid_i;
      // Payload only changes on a real transfer so a bubble leaves it intact.
      if (valid_i) begin
        data_q <= data_d;
        key_q  <= key_i;
        mode_q <= mode_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign key_o   = key_q;
  assign mode_o  = mode_q;

endmodule

// File: rtl/rotate_cipher_pipe.sv
// rotate_cipher_pipe
//   Valid/ready pipeline that rotates each word by a per-word key, one key
//   bit per stage (KEY_W = log2(WIDTH) stages, latency KEY_W cycles). The key
//   rolls by cfg_step after each accepted word. Configuration loads are only
//   taken while the pipeline is empty; a refused load pulses cfg_err.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_load/key/step/decrypt  configuration request
//   cfg_err                  one-cycle pulse after a refused cfg_load
//   in_valid/in_ready/in_data   input stream
//   out_valid/out_ready/out_data output stream
//   busy                     any stage holds a word
module rotate_cipher_pipe
  import rotate_cipher_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned KEY_W = log2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [KEY_W-1:0] cfg_key,
  input  logic [KEY_W-1:0] cfg_step,
  input  logic             cfg_decrypt,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  // Stage interconnect; index gi feeds stage gi, index KEY_W is the output.
  logic             valid_a [0:KEY_W];
  logic             ready_a [0:KEY_W];
  logic [WIDTH-1:0] data_a  [0:KEY_W];
  logic [KEY_W-1:0] key_a   [0:KEY_W];
  mode_e            mode_a  [0:KEY_W];

  logic [KEY_W-1:0] cur_key_q;
  logic [KEY_W-1:0] cur_key_d;
  logic [KEY_W-1:0] cfg_step_q;
  mode_e            mode_q;
  logic             cfg_err_q;

  logic             in_fire;
  logic             cfg_accept;
  logic             busy_c;

  // Intake is closed during reset and whenever a config load is requested.
  assign in_ready   = !rst && ready_a[0] && !cfg_load;
  assign in_fire    = in_valid && in_ready;
  assign cfg_accept = cfg_load && !busy_c && !(out_valid && out_ready);

  assign valid_a[0]     = in_fire;
  assign data_a[0]      = in_data;
  assign key_a[0]       = cur_key_q;
  assign mode_a[0]      = mode_q;
  assign ready_a[KEY_W] = out_ready;

  for (genvar gi = 0; gi < KEY_W; gi++) begin : g_stage
    rot_stage #(
      .WIDTH (WIDTH),
      .KEY_W (KEY_W),
      .STAGE (gi)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .valid_i (valid_a[gi]),
      .ready_o (ready_a[gi]),
      .data_i  (data_a[gi]),
      .key_i   (key_a[gi]),
      .mode_i  (mode_a[gi]),
      .valid_o (valid_a[gi+1]),
      .ready_i (ready_a[gi+1]),
      .data_o  (data_a[gi+1]),
      .key_o   (key_a[gi+1]),
      .mode_o  (mode_a[gi+1])
    );
  end

  // The final stage's key and mode have no consumer once the word leaves.
  logic [KEY_W:0] tail_meta_unused;
  assign tail_meta_unused = {mode_a[KEY_W], key_a[KEY_W]};

  always_comb begin
    busy_c = 1'b0;
    for (int i = 1; i <= int'(KEY_W); i++) busy_c = busy_c | valid_a[i];
  end

  always_comb begin
    cur_key_d = cur_key_q;
    if (cfg_accept)   cur_key_d = cfg_key;
    else if (in_fire) cur_key_d = cur_key_q + cfg_step_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_key_q  <= '0;
      cfg_step_q <= '0;
      mode_q     <= MODE_ENC;
      cfg_err_q  <= 1'b0;
    end else begin
      cur_key_q <= cur_key_d;
      cfg_err_q <= cfg_load && !cfg_accept;
      if (cfg_accept) begin
        cfg_step_q <= cfg_step;
        mode_q     <= mode_e'(cfg_decrypt);
      end
    end
  end

  assign out_valid = valid_a[KEY_W];
  assign out_data  = data_a[KEY_W];
  assign cfg_err   = cfg_err_q;
  assign busy      = busy_c;

endmodule

// File: tb/tb_rotate_cipher_pipe.sv
module tb_rotate_cipher_pipe;

  localparam int W  = 8;
  localparam int KW = 3;

  logic          clk;
  logic          rst;
  logic          cfg_load;
  logic [KW-1:0] cfg_key;
  logic [KW-1:0] cfg_step;
  logic          cfg_decrypt;
  logic          cfg_err;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;

  rotate_cipher_pipe #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_key     (cfg_key),
    .cfg_step    (cfg_step),
    .cfg_decrypt (cfg_decrypt),
    .cfg_err     (cfg_err),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [KW-1:0] key;
    logic [KW-1:0] step;
    logic          mode;
    logic [W-1:0]  din;
    logic [W-1:0]  dout;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    int           t;
  } sb_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_pulses = 0;
  bit check_lat = 1'b1;
  bit in_xfer = 1'b0;
  bit exp_err = 1'b0;

  // Reference model of the configuration state.
  logic [KW-1:0] m_key  = '0;
  logic [KW-1:0] m_step = '0;
  logic          m_mode = 1'b0;

  sb_t          sb[$];
  logic [W-1:0] out_log[$];
  int           out_cyc[$];
  vec_t         vecs[8];

  function automatic logic [W-1:0] rot_model(input logic [W-1:0] d, input logic [KW-1:0] k, input logic m);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (!m) r[(i + int'(k)) % W] = d[i];
      else    r[(i + W - int'(k)) % W] = d[i];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Called at the falling edge: compares status against the model, then
  // records the handshakes that will complete at the next rising edge.
  task automatic sample();
    sb_t it;
    in_xfer = 1'b0;
    if (rst) begin
      sb.delete();
      m_key = '0; m_step = '0; m_mode = 1'b0;
      exp_err = 1'b0;
      return;
    end
    check("cfg_err", cfg_err, exp_err);
    check("busy", busy, sb.size() != 0);
    if (cfg_err) err_pulses++;
    if (cfg_load) check("in_ready_during_cfg", in_ready, 0);
    exp_err = 1'b0;
    if (cfg_load) begin
      if (sb.size() == 0) begin
        m_key = cfg_key; m_step = cfg_step; m_mode = cfg_decrypt;
        $display("cfg   accepted key=%0d step=%0d mode=%0d", cfg_key, cfg_step, cfg_decrypt);
      end else begin
        exp_err = 1'b1;
        $display("cfg   refused (words in flight=%0d)", sb.size());
      end
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_output");
      end else begin
        it = sb.pop_front();
        $display("out   data=0x%02h expected=0x%02h latency=%0d", out_data, it.data, cyc - it.t);
        check("out_data", out_data, it.data);
        if (check_lat) check("latency", cyc - it.t, 3);
      end
      out_log.push_back(out_data);
      out_cyc.push_back(cyc);
    end
    if (in_valid && in_ready) begin
      in_xfer = 1'b1;
      $display("in    data=0x%02h key=%0d mode=%0d", in_data, m_key, m_mode);
      sb.push_back('{rot_model(in_data, m_key, m_mode), cyc});
      m_key = m_key + m_step;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_cfg(input logic [KW-1:0] k, input logic [KW-1:0] s, input logic m);
    cfg_load = 1'b1; cfg_key = k; cfg_step = s; cfg_decrypt = m;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 20 && !done; t++) begin
      tick();
      done = in_xfer;
    end
    if (!done) fail_now("send_timeout");
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (out_log.size() < n && t < 50) begin
      tick();
      t++;
    end
    if (out_log.size() < n) fail_now("wait_output");
  endtask

  initial begin
    logic [W-1:0] words[5];
    logic [W-1:0] bp_exp[5];
    logic [W-1:0] held;
    int sent;
    int t;

    vecs[0] = '{3'd1, 3'd0, 1'b0, 8'h81, 8'h03};
    vecs[1] = '{3'd1, 3'd0, 1'b1, 8'h03, 8'h81};
    vecs[2] = '{3'd0, 3'd0, 1'b0, 8'hA5, 8'hA5};
    vecs[3] = '{3'd0, 3'd0, 1'b1, 8'hA5, 8'hA5};
    vecs[4] = '{3'd4, 3'd0, 1'b0, 8'h12, 8'h21};
    vecs[5] = '{3'd3, 3'd0, 1'b1, 8'h01, 8'h20};
    vecs[6] = '{3'd7, 3'd3, 1'b0, 8'h01, 8'h80};
    vecs[7] = '{3'd5, 3'd0, 1'b1, 8'hF0, 8'h87};

    rst = 1'b1; cfg_load = 1'b0; cfg_key = '0; cfg_step = '0; cfg_decrypt = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1);

    // Table-driven single-word vectors, each against a fresh static config
    for (int i = 0; i < 8; i++) begin
      out_log.delete();
      do_cfg(vecs[i].key, vecs[i].step, vecs[i].mode);
      send(vecs[i].din);
      in_valid = 1'b0;
      wait_out(1);
      check($sformatf("vec%0d", i), out_log[0], vecs[i].dout);
    end

    // Rolling key wrapping 7 -> 1 -> 3, back-to-back words
    out_log.delete(); out_cyc.delete();
    do_cfg(3'd7, 3'd2, 1'b0);
    send(8'h01); send(8'h01); send(8'h01);
    in_valid = 1'b0;
    wait_out(3);
    check("roll0", out_log[0], 8'h80);
    check("roll1", out_log[1], 8'h02);
    check("roll2", out_log[2], 8'h08);
    check("roll_back_to_back", out_cyc[2] - out_cyc[0], 2);

    // Backpressure: 6 stalled cycles with 5 words offered
    words  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bp_exp = '{8'h44, 8'h11, 8'h33, 8'h88, 8'h55};
    do_cfg(3'd2, 3'd1, 1'b0);
    out_log.delete();
    check_lat = 1'b0;
    out_ready = 1'b0;
    sent = 0;
    held = '0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = words[sent];
      tick();
      if (in_xfer) sent++;
      if (c == 3) held = out_data;
    end
    check("bp_accepted_when_stalled", sent, 3);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid_held", out_valid, 1);
    check("bp_out_data_stable", out_data, held);
    check("bp_head_word", out_data, 8'h44);
    out_ready = 1'b1;
    t = 0;
    while (out_log.size() < 5 && t < 40) begin
      if (sent < 5) begin
        in_valid = 1'b1;
        in_data  = words[sent];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (in_xfer) sent++;
      t++;
    end
    in_valid = 1'b0;
    if (out_log.size() < 5) fail_now("bp_drain");
    for (int i = 0; i < 5; i++) check($sformatf("bp_word%0d", i), out_log[i], bp_exp[i]);
    check_lat = 1'b1;

    // Config while busy: refused with one cfg_err pulse, old key still used
    do_cfg(3'd1, 3'd0, 1'b0);
    out_log.delete();
    err_pulses = 0;
    send(8'h81); send(8'h40);
    in_valid = 1'b0;
    do_cfg(3'd5, 3'd0, 1'b1);
    wait_out(2);
    check("busy_cfg_out0", out_log[0], 8'h03);
    check("busy_cfg_out1", out_log[1], 8'h80);
    check("busy_cfg_err_pulses", err_pulses, 1);
    out_log.delete();
    do_cfg(3'd5, 3'd0, 1'b1);
    send(8'hF0);
    in_valid = 1'b0;
    wait_out(1);
    check("idle_cfg_applied", out_log[0], 8'h87);
    check("idle_cfg_no_err", err_pulses, 1);

    // Reset with three words in flight
    do_cfg(3'd3, 3'd1, 1'b0);
    out_log.delete();
    send(8'h01); send(8'h02); send(8'h03);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_cfg_err", cfg_err, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    repeat (5) tick();
    check("flushed_words_absent", out_log.size(), 0);
    send(8'h5A);
    in_valid = 1'b0;
    wait_out(1);
    check("post_rst_key0", out_log[0], 8'h5A);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
